phase1_stage_seq: RTL and testbench
===================================

PHASE1_STAGE_SEQ -- requirements
Module: phase1_stage_seq

Interface
REQ-001 Parameter NUM_PUZZLES, default 3: number of puzzle sub-blocks sequenced; legal range 2-4.
REQ-002 Parameter MAX_LIVES, default 3: fail budget per phase run; legal range 1-3.
REQ-003 Parameter CLK_FREQ, default 50_000_000: clk cycles per 1-second tick.
REQ-004 Parameter PHASE_TIME_SEC, default 60: phase time budget in seconds; legal range 1-255.
REQ-005 Parameter HOLD_CYC, default 25_000_000: inter-puzzle display hold in cycles; minimum 1.
REQ-006 clk  input  1  system clock; all logic rising-edge.
REQ-007 rst_n  input  1  reset, asynchronous, active-low.
REQ-008 start  input  1  single-cycle pulse requesting a phase (re)start.
REQ-009 puzzle_clear  input  NUM_PUZZLES  per-puzzle 1-cycle clear pulses.
REQ-010 puzzle_fail  input  NUM_PUZZLES  per-puzzle 1-cycle fail pulses.
REQ-011 puzzle_seg  input  32*NUM_PUZZLES  per-puzzle 8-digit nibble display words; puzzle i occupies bits [32i+31:32i].
REQ-012 puzzle_en  output  NUM_PUZZLES  one-hot enable to the active puzzle, else all zero.
REQ-013 seg_data  output  32  shared 7-segment word, 8 nibbles, digit 0 in bits [3:0].
REQ-014 lives  output  2  remaining lives.
REQ-015 remaining_sec  output  8  seconds left in the phase.
REQ-016 stage_idx  output  2  index of the current puzzle.
REQ-017 phase_done  output  1  level; high while in DONE.
REQ-018 game_over  output  1  level; high while in OVER.

Function
REQ-019 States SHALL be IDLE, ARM, RUN, INTER, DONE, OVER; all outputs SHALL be registered.
REQ-020 IDLE: on start -> ARM; stage_idx=0, lives=MAX_LIVES, remaining_sec=PHASE_TIME_SEC, tick counter=0.
REQ-021 ARM: lasts exactly 1 cycle with puzzle_en=0, so the target puzzle re-initialises; then -> RUN.
REQ-022 RUN: puzzle_en SHALL equal 1<<stage_idx; clear/fail bits at other indices SHALL be ignored.
REQ-023 RUN, active clear: if stage_idx==NUM_PUZZLES-1 -> DONE, else -> INTER with hold counter=HOLD_CYC.
REQ-024 RUN, active fail: lives decrements; if lives was 1 -> OVER (lives=0); else stay in RUN.
REQ-025 The tick counter SHALL count 0..CLK_FREQ-1 in ARM, RUN and INTER; on wrap, remaining_sec decrements, saturating at 0.
REQ-026 RUN with remaining_sec==0 SHALL go -> OVER on the next cycle.
REQ-027 Same-cycle priority in RUN: clear > timeout > fail; a clear on the same cycle as a fail SHALL NOT cost a life.
REQ-028 INTER: puzzle_en=0; hold counter decrements each cycle; at 1 -> ARM with stage_idx+1; timer keeps running; a timeout during INTER SHALL take effect in RUN, not in INTER.
REQ-029 DONE/OVER: puzzle_en=0, timer frozen; start -> ARM with full reinitialisation per REQ-020.
REQ-030 start SHALL be ignored in ARM, RUN and INTER.
REQ-031 seg_data: RUN = puzzle_seg slice of stage_idx, with a 1-cycle register latency; ARM/IDLE = 0; INTER = 32'hAAAAAAAA; DONE = 32'hCCCCCCCC; OVER = 32'hEEEEEEEE.
REQ-032 stage_idx SHALL never exceed NUM_PUZZLES-1; lives SHALL never underflow.

Reset
REQ-033 On rst_n low, all state SHALL asynchronously go to: IDLE, puzzle_en=0, seg_data=0, lives=MAX_LIVES, remaining_sec=PHASE_TIME_SEC, stage_idx=0, phase_done=0, game_over=0, all counters 0.
REQ-034 Reset mid-RUN SHALL drop puzzle_en within the same cycle; after release the block SHALL wait in IDLE for start.

Verification (CLK_FREQ=10, PHASE_TIME_SEC=5, HOLD_CYC=4, NUM_PUZZLES=3, MAX_LIVES=3)
REQ-035 Happy path: start; clear puzzles 0, 1, 2 in turn -> puzzle_en 001 / 010 / 100, each preceded by a 1-cycle 000 ARM gap; INTER lasts 4 cycles showing AAAAAAAA; DONE with phase_done=1 and seg_data=CCCCCCCC.
REQ-036 Lives: three puzzle_fail[0] pulses -> lives 3->2->1->0; after the third, game_over=1, seg_data=EEEEEEEE, puzzle_en=0.
REQ-037 Timeout: start, no clear -> remaining_sec decrements every 10 cycles 5->0 -> OVER one cycle after reaching 0.
REQ-038 Collision: clear[0] and fail[0] on the same cycle -> INTER, lives stays 3; fail[2] while stage 0 is active -> ignored.
REQ-039 Reset mid-RUN at stage 1 -> IDLE, all outputs at reset values; start then restarts at stage 0 with lives=3 and remaining_sec=5.
REQ-040 Restart: start in OVER -> ARM then RUN at stage 0 with full lives; start during RUN -> no effect.

Source files
------------

// File: rtl/phase1_stage_seq.sv
// Phase-1 puzzle stage sequencer: arms each puzzle in turn and tracks lives and the phase countdown.
// Every output is registered; the 7-segment word is muxed from the active puzzle or status patterns.
//
// state   | meaning
// IDLE    | waiting for start after reset
// ARM     | one-cycle gap with puzzle_en low so the target puzzle re-initialises
// RUN     | active puzzle enabled, watching clear/fail/timeout
// INTER   | hold between puzzles, showing AAAAAAAA
// DONE    | all puzzles cleared
// OVER    | out of lives or out of time
module phase1_stage_seq #(
  parameter int NUM_PUZZLES    = 3,
  parameter int MAX_LIVES      = 3,
  parameter int CLK_FREQ       = 50_000_000,
  parameter int PHASE_TIME_SEC = 60,
  parameter int HOLD_CYC       = 25_000_000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [NUM_PUZZLES-1:0]   puzzle_clear,
  input  logic [NUM_PUZZLES-1:0]   puzzle_fail,
  input  logic [32*NUM_PUZZLES-1:0] puzzle_seg,
  output logic [NUM_PUZZLES-1:0]   puzzle_en,
  output logic [31:0]              seg_data,
  output logic [1:0]               lives,
  output logic [7:0]               remaining_sec,
  output logic [1:0]               stage_idx,
  output logic                     phase_done,
  output logic                     game_over
);

  localparam int TW = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
  localparam int HW = $clog2(HOLD_CYC + 1);

  localparam logic [31:0] SEG_INTER = 32'hAAAA_AAAA;
  localparam logic [31:0] SEG_DONE  = 32'hCCCC_CCCC;
  localparam logic [31:0] SEG_OVER  = 32'hEEEE_EEEE;

  typedef enum logic [2:0] {S_IDLE, S_ARM, S_RUN, S_INTER, S_DONE, S_OVER} state_t;

  state_t                  r_state;
  logic [TW-1:0]           r_tick;
  logic [HW-1:0]           r_hold;
  logic [1:0]              r_stage;
  logic [1:0]              r_lives;
  logic [7:0]              r_sec;
  logic [NUM_PUZZLES-1:0]  r_en;
  logic [31:0]             r_seg;
  logic                    r_done;
  logic                    r_over;

  logic [NUM_PUZZLES-1:0]  w_sel;
  logic                    w_clr;
  logic                    w_fail;
  logic                    w_wrap;
  logic                    w_timer_on;
  logic [31:0]             w_slice;

  // Clear/fail bits of inactive puzzles are masked out here
  assign w_sel      = NUM_PUZZLES'(1) << r_stage;
  assign w_clr      = |(puzzle_clear & w_sel);
  assign w_fail     = |(puzzle_fail & w_sel);
  assign w_wrap     = (r_tick == TW'(CLK_FREQ - 1));
  assign w_timer_on = (r_state == S_ARM) || (r_state == S_RUN) || (r_state == S_INTER);
  assign w_slice    = puzzle_seg[{r_stage, 5'd0} +: 32];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_tick  <= '0;
      r_hold  <= '0;
      r_stage <= '0;
      r_lives <= 2'(MAX_LIVES);
      r_sec   <= 8'(PHASE_TIME_SEC);
      r_en    <= '0;
      r_seg   <= '0;
      r_done  <= 1'b0;
      r_over  <= 1'b0;
    end else begin
      if (w_timer_on) begin
        r_tick <= w_wrap ? '0 : r_tick + TW'(1);
        if (w_wrap && (r_sec != 8'd0))
          r_sec <= r_sec - 8'd1;
      end

      case (r_state)
        S_IDLE, S_DONE, S_OVER: begin
          if (start) begin
            r_state <= S_ARM;
            r_stage <= '0;
            r_lives <= 2'(MAX_LIVES);
            r_sec   <= 8'(PHASE_TIME_SEC);
            r_tick  <= '0;
            r_hold  <= '0;
            r_en    <= '0;
            r_seg   <= '0;
            r_done  <= 1'b0;
            r_over  <= 1'b0;
          end
        end
        S_ARM: begin
          r_state <= S_RUN;
          r_en    <= w_sel;
          r_seg   <= w_slice;
        end
        S_RUN: begin
          // clear beats timeout beats fail
          if (w_clr) begin
            r_en <= '0;
            if (r_stage == 2'(NUM_PUZZLES - 1)) begin
              r_state <= S_DONE;
              r_seg   <= SEG_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_INTER;
              r_hold  <= HW'(HOLD_CYC);
              r_seg   <= SEG_INTER;
            end
          end else if (r_sec == 8'd0) begin
            r_state <= S_OVER;
            r_en    <= '0;
            r_seg   <= SEG_OVER;
            r_over  <= 1'b1;
          end else if (w_fail && (r_lives <= 2'd1)) begin
            r_state <= S_OVER;
            r_lives <= 2'd0;
            r_en    <= '0;
            r_seg   <= SEG_OVER;
            r_over  <= 1'b1;
          end else begin
            r_seg <= w_slice;
            if (w_fail)
              r_lives <= r_lives - 2'd1;
          end
        end
        S_INTER: begin
          if (r_hold <= HW'(1)) begin
            r_state <= S_ARM;
            r_stage <= r_stage + 2'd1;
            r_seg   <= '0;
          end else begin
            r_hold <= r_hold - HW'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign puzzle_en     = r_en;
  assign seg_data      = r_seg;
  assign lives         = r_lives;
  assign remaining_sec = r_sec;
  assign stage_idx     = r_stage;
  assign phase_done    = r_done;
  assign game_over     = r_over;

endmodule

// File: tb/tb_phase1_stage_seq.sv
// Bench for phase1_stage_seq: directed scenarios plus a randomized run against a
// behavioural model that derives time left from elapsed cycles and INTER from a countdown.
module tb_phase1_stage_seq;

  localparam int NP = 3;
  localparam int ML = 3;
  localparam int CF = 10;
  localparam int PT = 5;
  localparam int HC = 4;

  localparam int M_IDLE = 0, M_ARM = 1, M_RUN = 2, M_INTER = 3, M_DONE = 4, M_OVER = 5;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic [NP-1:0]  puzzle_clear = '0;
  logic [NP-1:0]  puzzle_fail = '0;
  logic [32*NP-1:0] puzzle_seg = '0;
  logic [NP-1:0]  puzzle_en;
  logic [31:0]    seg_data;
  logic [1:0]     lives;
  logic [7:0]     remaining_sec;
  logic [1:0]     stage_idx;
  logic           phase_done;
  logic           game_over;

  int n_checks = 0;
  int n_fails  = 0;

  phase1_stage_seq #(
    .NUM_PUZZLES(NP), .MAX_LIVES(ML), .CLK_FREQ(CF),
    .PHASE_TIME_SEC(PT), .HOLD_CYC(HC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .puzzle_clear(puzzle_clear), .puzzle_fail(puzzle_fail), .puzzle_seg(puzzle_seg),
    .puzzle_en(puzzle_en), .seg_data(seg_data), .lives(lives),
    .remaining_sec(remaining_sec), .stage_idx(stage_idx),
    .phase_done(phase_done), .game_over(game_over)
  );

  always #5 clk = ~clk;

  // Reference model
  int          m_mode;
  int          m_stage;
  int          m_lives;
  int          m_elapsed;
  int          m_inter_left;
  logic [31:0] m_seg;

  function automatic void model_reset();
    m_mode = M_IDLE; m_stage = 0; m_lives = ML; m_elapsed = 0; m_inter_left = 0; m_seg = '0;
  endfunction

  function automatic int model_sec();
    return (m_elapsed / CF >= PT) ? 0 : PT - m_elapsed / CF;
  endfunction

  function automatic void model_step(input logic s, input logic [NP-1:0] c, input logic [NP-1:0] f);
    int  cur_sec = model_sec();
    bit  timed = (m_mode == M_ARM) || (m_mode == M_RUN) || (m_mode == M_INTER);
    logic [31:0] slice = puzzle_seg[32*m_stage +: 32];
    case (m_mode)
      M_IDLE, M_DONE, M_OVER:
        if (s) begin
          m_mode = M_ARM; m_stage = 0; m_lives = ML; m_elapsed = 0; timed = 0;
        end
      M_ARM: begin m_mode = M_RUN; m_seg = slice; end
      M_RUN:
        if (c[m_stage]) begin
          if (m_stage == NP - 1) m_mode = M_DONE;
          else begin m_mode = M_INTER; m_inter_left = HC; end
        end else if (cur_sec == 0) begin
          m_mode = M_OVER;
        end else begin
          m_seg = slice;
          if (f[m_stage]) begin
            m_lives = m_lives - 1;
            if (m_lives == 0) m_mode = M_OVER;
          end
        end
      M_INTER: begin
        m_inter_left = m_inter_left - 1;
        if (m_inter_left == 0) begin m_mode = M_ARM; m_stage = m_stage + 1; end
      end
      default: m_mode = M_IDLE;
    endcase
    if (timed) m_elapsed = m_elapsed + 1;
  endfunction

  function automatic logic [NP-1:0] exp_en();
    return (m_mode == M_RUN) ? NP'(1 << m_stage) : '0;
  endfunction

  function automatic logic [31:0] exp_seg();
    case (m_mode)
      M_RUN:   return m_seg;
      M_INTER: return 32'hAAAA_AAAA;
      M_DONE:  return 32'hCCCC_CCCC;
      M_OVER:  return 32'hEEEE_EEEE;
      default: return 32'h0;
    endcase
  endfunction

  task automatic cyc(input logic s, input logic [NP-1:0] c, input logic [NP-1:0] f);
    start = s; puzzle_clear = c; puzzle_fail = f;
    @(posedge clk);
    model_step(s, c, f);
    #1;
    start = 1'b0; puzzle_clear = '0; puzzle_fail = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({puzzle_en, seg_data, lives, remaining_sec, stage_idx, phase_done, game_over} !==
        {3'b000, 32'h0, 2'd3, 8'd5, 2'd0, 1'b0, 1'b0}) begin
      n_fails++;
      $display("FAIL reset_values en=%b seg=%h lives=%0d sec=%0d stage=%0d done=%b over=%b exp en=000 seg=0 lives=3 sec=5 stage=0 done=0 over=0",
               puzzle_en, seg_data, lives, remaining_sec, stage_idx, phase_done, game_over);
    end
    rst_n = 1'b1;
    repeat (2) cyc(1'b0, '0, '0);
    n_checks++;
    if (puzzle_en !== 3'b000) begin
      n_fails++; $display("FAIL idle_wait en=%b exp=000", puzzle_en);
    end
  endtask

  task automatic test_happy_path();
    puzzle_seg = {32'h2222_2222, 32'h1111_1111, 32'h0123_4567};
    cyc(1'b1, '0, '0);
    for (int p = 0; p < NP; p++) begin
      n_checks++;
      if (puzzle_en !== 3'b000 || stage_idx !== 2'(p)) begin
        n_fails++; $display("FAIL arm_gap p=%0d en=%b stage=%0d exp en=000 stage=%0d", p, puzzle_en, stage_idx, p);
      end
      cyc(1'b0, '0, '0);
      n_checks++;
      if (puzzle_en !== NP'(1 << p) || seg_data !== puzzle_seg[32*p +: 32]) begin
        n_fails++; $display("FAIL run_en p=%0d en=%b seg=%h exp en=%b seg=%h", p, puzzle_en, seg_data, NP'(1 << p), puzzle_seg[32*p +: 32]);
      end
      cyc(1'b0, NP'(1 << p), '0);
      if (p < NP - 1) begin
        for (int i = 0; i < HC; i++) begin
          n_checks++;
          if (puzzle_en !== 3'b000 || seg_data !== 32'hAAAA_AAAA) begin
            n_fails++; $display("FAIL inter_hold p=%0d i=%0d en=%b seg=%h exp en=000 seg=aaaaaaaa", p, i, puzzle_en, seg_data);
          end
          cyc(1'b0, '0, '0);
        end
      end
    end
    n_checks++;
    if (phase_done !== 1'b1 || seg_data !== 32'hCCCC_CCCC || puzzle_en !== 3'b000 || game_over !== 1'b0) begin
      n_fails++; $display("FAIL done_state done=%b seg=%h en=%b over=%b exp done=1 seg=cccccccc en=000 over=0", phase_done, seg_data, puzzle_en, game_over);
    end
  endtask

  task automatic test_lives();
    cyc(1'b1, '0, '0);
    cyc(1'b0, '0, '0);
    for (int k = 1; k <= ML; k++) begin
      cyc(1'b0, '0, 3'b001);
      n_checks++;
      if (lives !== 2'(ML - k)) begin
        n_fails++; $display("FAIL lives_dec k=%0d lives=%0d exp=%0d", k, lives, ML - k);
      end
    end
    n_checks++;
    if (game_over !== 1'b1 || seg_data !== 32'hEEEE_EEEE || puzzle_en !== 3'b000) begin
      n_fails++; $display("FAIL lives_over over=%b seg=%h en=%b exp over=1 seg=eeeeeeee en=000", game_over, seg_data, puzzle_en);
    end
  endtask

  task automatic test_timeout();
    cyc(1'b1, '0, '0);
    for (int k = 1; k <= PT * CF; k++) begin
      cyc(1'b0, '0, '0);
      if (k % CF == 0) begin
        n_checks++;
        if (remaining_sec !== 8'(PT - k / CF) || game_over !== 1'b0) begin
          n_fails++; $display("FAIL timeout_count k=%0d sec=%0d over=%b exp sec=%0d over=0", k, remaining_sec, game_over, PT - k / CF);
        end
      end
    end
    cyc(1'b0, '0, '0);
    n_checks++;
    if (game_over !== 1'b1 || seg_data !== 32'hEEEE_EEEE || remaining_sec !== 8'd0) begin
      n_fails++; $display("FAIL timeout_over over=%b seg=%h sec=%0d exp over=1 seg=eeeeeeee sec=0", game_over, seg_data, remaining_sec);
    end
    cyc(1'b0, '0, '0);
    n_checks++;
    if (remaining_sec !== 8'd0 || game_over !== 1'b1) begin
      n_fails++; $display("FAIL timeout_hold sec=%0d over=%b exp sec=0 over=1", remaining_sec, game_over);
    end
  endtask

  task automatic test_collision();
    cyc(1'b1, '0, '0);
    cyc(1'b0, '0, '0);
    cyc(1'b0, '0, 3'b100);
    n_checks++;
    if (lives !== 2'd3 || puzzle_en !== 3'b001) begin
      n_fails++; $display("FAIL other_fail_ignored lives=%0d en=%b exp lives=3 en=001", lives, puzzle_en);
    end
    cyc(1'b0, 3'b001, 3'b001);
    n_checks++;
    if (lives !== 2'd3 || puzzle_en !== 3'b000 || seg_data !== 32'hAAAA_AAAA) begin
      n_fails++; $display("FAIL clear_beats_fail lives=%0d en=%b seg=%h exp lives=3 en=000 seg=aaaaaaaa", lives, puzzle_en, seg_data);
    end
  endtask

  task automatic test_reset_mid_run();
    repeat (HC + 1) cyc(1'b0, '0, '0);
    n_checks++;
    if (puzzle_en !== 3'b010 || stage_idx !== 2'd1) begin
      n_fails++; $display("FAIL stage1_run en=%b stage=%0d exp en=010 stage=1", puzzle_en, stage_idx);
    end
    rst_n = 1'b0;
    #1;
    model_reset();
    n_checks++;
    if ({puzzle_en, seg_data, lives, remaining_sec, stage_idx, phase_done, game_over} !==
        {3'b000, 32'h0, 2'd3, 8'd5, 2'd0, 1'b0, 1'b0}) begin
      n_fails++; $display("FAIL async_reset en=%b seg=%h lives=%0d sec=%0d stage=%0d exp en=000 seg=0 lives=3 sec=5 stage=0",
                          puzzle_en, seg_data, lives, remaining_sec, stage_idx);
    end
    rst_n = 1'b1;
    repeat (3) cyc(1'b0, '0, '0);
    n_checks++;
    if (puzzle_en !== 3'b000 || seg_data !== 32'h0) begin
      n_fails++; $display("FAIL idle_after_reset en=%b seg=%h exp en=000 seg=0", puzzle_en, seg_data);
    end
    cyc(1'b1, '0, '0);
    cyc(1'b0, '0, '0);
    n_checks++;
    if (puzzle_en !== 3'b001 || lives !== 2'd3 || remaining_sec !== 8'd5 || stage_idx !== 2'd0) begin
      n_fails++; $display("FAIL restart_after_reset en=%b lives=%0d sec=%0d stage=%0d exp en=001 lives=3 sec=5 stage=0",
                          puzzle_en, lives, remaining_sec, stage_idx);
    end
  endtask

  task automatic test_restart();
    repeat (ML) cyc(1'b0, '0, 3'b001);
    cyc(1'b1, '0, '0);
    n_checks++;
    if (puzzle_en !== 3'b000 || lives !== 2'd3 || game_over !== 1'b0 || seg_data !== 32'h0) begin
      n_fails++; $display("FAIL restart_arm en=%b lives=%0d over=%b seg=%h exp en=000 lives=3 over=0 seg=0", puzzle_en, lives, game_over, seg_data);
    end
    cyc(1'b0, '0, '0);
    n_checks++;
    if (puzzle_en !== 3'b001 || stage_idx !== 2'd0) begin
      n_fails++; $display("FAIL restart_run en=%b stage=%0d exp en=001 stage=0", puzzle_en, stage_idx);
    end
    cyc(1'b0, '0, 3'b001);
    cyc(1'b1, '0, '0);
    n_checks++;
    if (puzzle_en !== 3'b001 || lives !== 2'd2) begin
      n_fails++; $display("FAIL start_in_run_ignored en=%b lives=%0d exp en=001 lives=2", puzzle_en, lives);
    end
  endtask

  task automatic test_random();
    logic s;
    logic [NP-1:0] c, f;
    rst_n = 1'b0;
    #1;
    model_reset();
    rst_n = 1'b1;
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 15) == 0)
        puzzle_seg = {$urandom, $urandom, $urandom};
      s = ($urandom_range(0, 9) == 0);
      c = ($urandom_range(0, 7) == 0) ? NP'($urandom) : '0;
      f = ($urandom_range(0, 5) == 0) ? NP'($urandom) : '0;
      cyc(s, c, f);
      n_checks++;
      if ({puzzle_en, seg_data, lives, remaining_sec, stage_idx, phase_done, game_over} !==
          {exp_en(), exp_seg(), 2'(m_lives), 8'(model_sec()), 2'(m_stage),
           m_mode == M_DONE, m_mode == M_OVER}) begin
        n_fails++;
        $display("FAIL random n=%0d en=%b seg=%h lives=%0d sec=%0d stage=%0d done=%b over=%b exp en=%b seg=%h lives=%0d sec=%0d stage=%0d mode=%0d",
                 n, puzzle_en, seg_data, lives, remaining_sec, stage_idx, phase_done, game_over,
                 exp_en(), exp_seg(), m_lives, model_sec(), m_stage, m_mode);
      end
    end
  endtask

  initial begin
    model_reset();
    #2;
    test_reset();
    test_happy_path();
    test_lives();
    test_timeout();
    test_collision();
    test_reset_mid_run();
    test_restart();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end

endmodule
